// File: rtl/program_loader.sv
// Boot/load sequencer for the risc core.
// Streams program words into memory from address 0 while the core is held in reset,
// then releases the core and counts run cycles until the core halts.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | nothing loaded or load aborted; core held in reset
// LOAD   | accepting stream words, one memory write per transfer
// DRAIN  | one cycle for the final write to land in memory
// RUN    | core released, run-cycle counter advancing (saturating)
// HALTED | core halted; counter frozen, core left out of reset
module program_loader #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] len,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  mem_wr,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   input  logic                  halt,
   output logic                  cpu_rst,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_WIDTH-1:0]  run_cycles
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_DRAIN  = 3'd2,
      S_RUN    = 3'd3,
      S_HALTED = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   // one extra bit so len==0 can represent a full 2**ADDR_WIDTH word load
   logic [ADDR_WIDTH:0]   rem_q, rem_d;
   logic [CNT_WIDTH-1:0]  run_cycles_q, run_cycles_d;
   logic                  mem_wr_q, mem_wr_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
   logic                  cpu_rst_q, cpu_rst_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  xfer;

   assign in_ready = (state_q == S_LOAD);
   // a word presented together with abort is dropped
   assign xfer     = in_valid & in_ready & ~abort;

   // state register and all registered outputs, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         rem_q        <= '0;
         run_cycles_q <= '0;
         mem_wr_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         cpu_rst_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         rem_q        <= rem_d;
         run_cycles_q <= run_cycles_d;
         mem_wr_q     <= mem_wr_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         cpu_rst_q    <= cpu_rst_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   // next state plus load pointer, remaining count and run counter
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      rem_d        = rem_q;
      run_cycles_d = run_cycles_q;
      if (abort) begin
         state_d = S_IDLE;
         ptr_d   = '0;
         rem_d   = '0;
      end else begin
         case (state_q)
            S_IDLE, S_HALTED: begin
               if (start) begin
                  state_d      = S_LOAD;
                  ptr_d        = '0;
                  rem_d        = (len == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}} : {1'b0, len};
                  run_cycles_d = '0;
               end
            end
            S_LOAD: begin
               if (xfer) begin
                  ptr_d = ptr_q + ADDR_WIDTH'(1);
                  rem_d = rem_q - (ADDR_WIDTH + 1)'(1);
                  if (rem_q == (ADDR_WIDTH + 1)'(1)) begin
                     state_d = S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               state_d = S_RUN;
            end
            S_RUN: begin
               if (halt) begin
                  state_d = S_HALTED;
               end else if (run_cycles_q != {CNT_WIDTH{1'b1}}) begin
                  run_cycles_d = run_cycles_q + CNT_WIDTH'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // registered outputs derived from the upcoming state and the current transfer
   always_comb begin
      mem_wr_d   = xfer;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      if (xfer) begin
         mem_addr_d = ptr_q;
         mem_data_d = in_data;
      end
      cpu_rst_d = (state_d == S_RUN) || (state_d == S_HALTED);
      busy_d    = (state_d == S_LOAD) || (state_d == S_DRAIN) || (state_d == S_RUN);
      done_d    = (state_d == S_HALTED);
   end

   assign mem_wr     = mem_wr_q;
   assign mem_addr   = mem_addr_q;
   assign mem_data   = mem_data_q;
   assign cpu_rst    = cpu_rst_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus queues the memory writes it expects,
// a negedge monitor pops and compares every mem_wr pulse. A second instance with a
// 4-bit counter and halt tied low shares the stimulus to show counter saturation.
module tb_program_loader;
   localparam int AW = 5;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] len = '0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          halt = 1'b0;
   logic          halt2 = 1'b0;

   logic          in_ready, mem_wr, cpu_rst, busy, done;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic [15:0]   run_cycles;

   logic          in_ready2, mem_wr2, cpu_rst2, busy2, done2;
   logic [AW-1:0] mem_addr2;
   logic [DW-1:0] mem_data2;
   logic [3:0]    run_cycles2;

   program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data),
      .halt(halt), .cpu_rst(cpu_rst), .busy(busy), .done(done),
      .run_cycles(run_cycles)
   );

   program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_sat (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
      .mem_wr(mem_wr2), .mem_addr(mem_addr2), .mem_data(mem_data2),
      .halt(halt2), .cpu_rst(cpu_rst2), .busy(busy2), .done(done2),
      .run_cycles(run_cycles2)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;
   wr_t exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // monitor: every write must match the oldest outstanding expected write
   always @(negedge clk) begin
      if (mem_wr === 1'b1) begin
         chk("wr_while_core_running", cpu_rst, 0);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", mem_addr, e.a);
            chk("wr_data", mem_data, e.d);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_mem_wr"}, mem_wr, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_data"}, mem_data, 0);
      chk({tag, "_cpu_rst"}, cpu_rst, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_run_cycles"}, run_cycles, 0);
      chk({tag, "_in_ready"}, in_ready, 0);
   endtask

   task automatic do_start(input int l);
      len   = AW'(l);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_done", done, 0);
      chk("start_cpu_rst", cpu_rst, 0);
      chk("start_run_cycles", run_cycles, 0);
      chk("start_in_ready", in_ready, 1);
   endtask

   // mode 0: random data, 1: data==index, 2: A0,B1,C2,...
   task automatic send_words(input int n, input int gap_min, input int gap_max, input int mode);
      for (int i = 0; i < n; i++) begin
         int gap;
         gap = (i == 0) ? 0 : int'($urandom_range(gap_max, gap_min));
         if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) tick();
         end
         case (mode)
            1:       in_data = DW'(i);
            2:       in_data = DW'(8'hA0 + 8'h11 * i);
            default: in_data = DW'($urandom);
         endcase
         in_valid = 1'b1;
         chk("in_ready_load", in_ready, 1);
         exp_q.push_back('{a: AW'(i), d: in_data});
         tick();
         chk("wr_pulse", mem_wr, 1);
      end
      in_valid = 1'b0;
   endtask

   task automatic finish_load();
      chk("drain_in_ready", in_ready, 0);
      chk("drain_cpu_rst", cpu_rst, 0);
      chk("drain_busy", busy, 1);
      tick();
      chk("run_cpu_rst", cpu_rst, 1);
      chk("run_busy", busy, 1);
      chk("run_mem_wr", mem_wr, 0);
   endtask

   // called in the first RUN cycle; halt is raised during RUN cycle n
   task automatic run_and_halt(input int n);
      repeat (n - 1) tick();
      halt = 1'b1;
      tick();
      halt = 1'b0;
      chk("halt_run_cycles", run_cycles, 64'(n - 1));
      chk("halt_done", done, 1);
      chk("halt_busy", busy, 0);
      chk("halt_cpu_rst", cpu_rst, 1);
   endtask

   initial begin
      int n;
      int l;
      // reset held with start asserted
      start = 1'b1;
      repeat (3) tick();
      chk_reset_outputs("por");
      start = 1'b0;
      rst   = 1'b1;
      tick();
      chk("idle_busy", busy, 0);

      // len=3, A0 B1 C2 with one idle cycle between words
      do_start(3);
      send_words(3, 1, 1, 2);
      finish_load();

      // halt on the 10th RUN cycle, later halt toggles change nothing
      run_and_halt(10);
      for (int i = 0; i < 6; i++) begin
         halt = 1'($urandom);
         tick();
      end
      halt = 1'b0;
      chk("halted_run_cycles", run_cycles, 9);
      chk("halted_done", done, 1);
      chk("halted_cpu_rst", cpu_rst, 1);
      chk("halted_in_ready", in_ready, 0);
      repeat (4) tick();
      chk("sat_run_cycles", run_cycles2, 4'hF);
      chk("sat_busy", busy2, 1);
      chk("sat_done", done2, 0);

      // reload from HALTED with len=2
      do_start(2);
      send_words(2, 0, 2, 0);
      finish_load();
      run_and_halt(int'($urandom_range(30, 2)));

      // len=0: 32 back-to-back words, data==addr
      do_start(0);
      send_words(32, 0, 0, 1);
      finish_load();
      run_and_halt(int'($urandom_range(20, 1)));

      // abort together with the second transfer of len=4
      do_start(4);
      send_words(1, 0, 0, 0);
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      abort    = 1'b1;
      tick();
      abort    = 1'b0;
      in_valid = 1'b0;
      chk("abort_in_ready", in_ready, 0);
      chk("abort_cpu_rst", cpu_rst, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_mem_wr", mem_wr, 0);
      chk("abort_sat_run_cycles", run_cycles2, 4'hF);
      chk("abort_sat_cpu_rst", cpu_rst2, 0);
      repeat (2) tick();
      do_start(4);
      send_words(4, 0, 2, 0);
      finish_load();
      run_and_halt(int'($urandom_range(12, 1)));

      // random loads of random length
      for (int k = 0; k < 4; k++) begin
         l = int'($urandom_range(31, 0));
         n = (l == 0) ? 32 : l;
         do_start(l);
         send_words(n, 0, 2, 0);
         finish_load();
         run_and_halt(int'($urandom_range(40, 1)));
      end

      // reset mid-RUN, start ignored while reset is held
      do_start(1);
      send_words(1, 0, 0, 0);
      finish_load();
      repeat (3) tick();
      rst   = 1'b0;
      start = 1'b1;
      tick();
      chk_reset_outputs("rst_run");
      tick();
      chk_reset_outputs("rst_hold");
      chk("rst_sat_run_cycles", run_cycles2, 0);
      rst   = 1'b1;
      start = 1'b0;
      tick();
      chk("post_rst_busy", busy, 0);

      // reset mid-LOAD with a word on the stream
      do_start(3);
      send_words(1, 0, 0, 0);
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      rst      = 1'b0;
      tick();
      in_valid = 1'b0;
      chk_reset_outputs("rst_load");
      rst = 1'b1;
      tick();

      // fresh load after reset
      do_start(2);
      send_words(2, 0, 1, 0);
      finish_load();
      run_and_halt(5);

      repeat (3) tick();
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
